// File: rtl/fetch_queue.sv
// fetch_queue: DEPTH-entry instruction/PC FIFO between fetch and decode with flush and bubble output
module fetch_queue #(
    parameter int INSTR_W = 32,
    parameter int ADDR_W = 64,
    parameter int DEPTH = 4,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [INSTR_W-1:0]         in_instr,
    input  logic [ADDR_W-1:0]          in_pc,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [ADDR_W-1:0]          out_pc,
    input  logic                       out_ready,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("fetch_queue: DEPTH must be a power of two and at least 2");
    end

    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem [DEPTH];
    logic [PW-1:0]      rd_ptr, wr_ptr;
    logic               push, pop;

    assign in_ready  = count != CW'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready & ~flush;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : NOP_INSTR;
    assign out_pc    = out_valid ? pc_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // storage is deliberately unreset; pointers alone define what is live
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pc;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized + directed scoreboard bench for fetch_queue against a queue-based model
module tb_fetch_queue;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'hD503201F;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } item_t;

    logic        clk = 0;
    logic        reset, in_valid, out_ready, flush;
    logic [31:0] in_instr;
    logic [63:0] in_pc;
    logic        in_ready, out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [2:0]  count;

    item_t exp_q[$];
    int    occ = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    bit    started = 0;

    fetch_queue #(.INSTR_W(32), .ADDR_W(64), .DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .in_ready(in_ready), .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready), .flush(flush), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares the visible head against the oldest expected entry and retires it on consumption
    always @(negedge clk) begin
        if (started) begin
            chk("count", 64'(count), 64'(occ));
            chk("in_ready", 64'(in_ready), 64'(occ != DEPTH));
            chk("out_valid", 64'(out_valid), 64'(occ != 0));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_head: got pc %h expected no entry", out_pc);
                end else begin
                    chk("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
                    chk("out_pc", out_pc, exp_q[0].pc);
                    if (out_ready && !flush && !reset) void'(exp_q.pop_front());
                end
            end else begin
                chk("bubble_instr", 64'(out_instr), 64'(NOP));
                chk("bubble_pc", out_pc, 64'd0);
            end
        end
    end

    // Drive one cycle, then advance the occupancy model and expected queue by that edge
    task automatic cyc(bit iv, logic [31:0] ins, logic [63:0] p, bit ordy, bit fl = 0, bit rs = 0);
        bit acc, pp;
        in_valid = iv; in_instr = ins; in_pc = p; out_ready = ordy; flush = fl; reset = rs;
        @(posedge clk);
        #1;
        if (rs || fl) begin
            occ = 0;
            exp_q.delete();
        end else begin
            acc = iv && occ < DEPTH;
            pp = ordy && occ > 0;
            occ = occ + int'(acc) - int'(pp);
            if (acc) exp_q.push_back('{ins, p});
        end
    endtask

    function automatic logic [31:0] ins_of(logic [63:0] p);
        return 32'hA000_0000 ^ p[31:0];
    endfunction

    initial begin
        in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0; flush = 0; reset = 1;
        cyc(0, 0, 0, 0, 0, 1);
        started = 1;
        cyc(0, 0, 0, 0, 0, 1);
        chk("reset_count", 64'(count), 0);
        chk("reset_in_ready", 64'(in_ready), 1);
        chk("reset_out_instr", 64'(out_instr), 64'(NOP));

        for (int i = 0; i < 4; i++) cyc(1, ins_of(64'(4 * i)), 64'(4 * i), 0);
        chk("fill_count", 64'(count), 4);
        chk("fill_in_ready", 64'(in_ready), 0);
        cyc(1, ins_of(64'h10), 64'h10, 0);
        chk("overflow_count", 64'(count), 4);
        chk("overflow_head", out_pc, 64'h0);
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", out_pc, 64'(4 * i));
            cyc(0, 0, 0, 1);
        end
        chk("drained_valid", 64'(out_valid), 0);
        chk("drained_instr", 64'(out_instr), 64'(NOP));

        cyc(1, ins_of(64'h40), 64'h40, 0);
        for (int i = 0; i < 10; i++) begin
            chk("wrap_head", out_pc, 64'(64'h40 + 4 * i));
            cyc(1, ins_of(64'(64'h44 + 4 * i)), 64'(64'h44 + 4 * i), 1);
            chk("wrap_count", 64'(count), 1);
        end
        cyc(0, 0, 0, 1);

        cyc(1, 32'h8B020020, 64'h20, 0);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 0);
            chk("stall_instr", 64'(out_instr), 64'h8B020020);
            chk("stall_pc", out_pc, 64'h20);
            chk("stall_count", 64'(count), 1);
        end
        cyc(0, 0, 0, 1);

        for (int i = 0; i < 3; i++) cyc(1, ins_of(64'(64'h80 + 4 * i)), 64'(64'h80 + 4 * i), 0);
        chk("preflush_count", 64'(count), 3);
        cyc(1, ins_of(64'h100), 64'h100, 0, 1);
        chk("flush_count", 64'(count), 0);
        chk("flush_valid", 64'(out_valid), 0);
        chk("flush_in_ready", 64'(in_ready), 1);
        cyc(1, ins_of(64'h200), 64'h200, 0);
        chk("newpath_pc", out_pc, 64'h200);
        cyc(0, 0, 0, 1);

        cyc(1, ins_of(64'h280), 64'h280, 0);
        cyc(1, ins_of(64'h284), 64'h284, 0);
        cyc(1, ins_of(64'h300), 64'h300, 0, 1, 1);
        chk("rst_mid_count", 64'(count), 0);
        chk("rst_mid_in_ready", 64'(in_ready), 1);
        chk("rst_mid_pc", out_pc, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);

        cyc(1, ins_of(64'h400), 64'h400, 1);
        chk("lat_valid", 64'(out_valid), 1);
        chk("lat_pc", out_pc, 64'h400);
        cyc(0, 0, 0, 1);
        chk("lat_count", 64'(count), 0);

        for (int i = 0; i < 600; i++) begin
            logic [63:0] p;
            p = {32'h0, $urandom} & 64'hFFFF_FFFC;
            cyc($urandom_range(0, 9) < 7, $urandom, p, $urandom_range(0, 9) < 6,
                $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
        end
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 0, 1);
        chk("final_count", 64'(count), 0);
        chk("final_scoreboard", 64'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
